// File: rtl/seq_gen.sv
// Serial test-pattern transmitter: sends a fixed LEN-bit pattern MSB first,
// one bit every DIV clocks, and shows the current bit index on a 7-seg digit.
module seq_gen #(
  parameter int         DIV     = 20000000,
  parameter int         LEN     = 8,
  parameter logic [7:0] PATTERN = 8'b00001000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic repeat_en,
  output logic x,
  output logic busy,
  output logic done,
  output logic tick,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [26:0]    CNT_MAX  = 27'(DIV - 1);
  localparam logic [2:0]     IDX_LAST = 3'(LEN - 1);
  localparam logic [LEN-1:0] LOAD     = PATTERN[LEN-1:0];
  localparam logic [6:0]     BLANK    = 7'b1111111;

  state_t         state;
  state_t         next_state;
  logic [26:0]    cnt;
  logic [2:0]     idx;
  logic [LEN-1:0] shreg;
  logic [6:0]     seg;
  logic           last_tick;

  function automatic logic [6:0] seg_of(input logic [2:0] digit);
    case (digit)
      3'd0:    seg_of = 7'b0000001;
      3'd1:    seg_of = 7'b1001111;
      3'd2:    seg_of = 7'b0010010;
      3'd3:    seg_of = 7'b0000110;
      3'd4:    seg_of = 7'b1001100;
      3'd5:    seg_of = 7'b0100100;
      3'd6:    seg_of = 7'b0100000;
      default: seg_of = 7'b0001111;
    endcase
  endfunction

  assign busy      = (state == SEND);
  assign tick      = busy && (cnt == CNT_MAX);
  assign last_tick = tick && (idx == IDX_LAST);
  // The bit on the line is always the MSB of the shift register; the line idles high.
  assign x         = busy ? shreg[LEN-1] : 1'b1;
  assign {a, b, c, d, e, f, g} = seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SEND;
      SEND:    if (last_tick && !repeat_en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      seg   <= BLANK;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SEND: begin
          if (tick) begin
            cnt <= '0;
            if (idx != IDX_LAST) begin
              shreg <= {shreg[LEN-2:0], 1'b0};
              idx   <= idx + 3'd1;
              seg   <= seg_of(idx + 3'd1);
            end else if (repeat_en) begin
              // Wrap straight into the next pass with no idle gap.
              shreg <= LOAD;
              idx   <= '0;
              seg   <= seg_of(3'd0);
            end else begin
              idx  <= '0;
              seg  <= BLANK;
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 27'd1;
          end
        end
        default: begin
          cnt <= '0;
          seg <= BLANK;
          if (start && state == IDLE) begin
            idx   <= '0;
            shreg <= LOAD;
            seg   <= seg_of(3'd0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: a cycle-count model fills a scoreboard
// queue on each clock edge and the DUT outputs are compared on the falling edge.
module tb_seq_gen;

   localparam int         DIV     = 4;
   localparam int         LEN     = 8;
   localparam logic [7:0] PATTERN = 8'b00001000;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic repeat_en;
   logic x, busy, done, tick;
   logic a, b, c, d, e, f, g;

   int checks   = 0;
   int failures = 0;
   int busyCount, doneCount, tickCount;

   logic [10:0] expQ[$];

   bit mBusy;
   bit mDone;
   int mTime;

   always #5 clk = ~clk;

   seq_gen #(.DIV(DIV), .LEN(LEN), .PATTERN(PATTERN)) dut (
      .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
      .x(x), .busy(busy), .done(done), .tick(tick),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [6:0] segRef(input int digit);
      logic [6:0] table7 [8] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
      return table7[digit];
   endfunction

   // Expected {x,busy,done,tick,segs} from the time elapsed since the pass began.
   function automatic logic [10:0] modelOut();
      int bitNo;
      logic ex, et;
      logic [6:0] es;
      bitNo = mTime / DIV;
      ex = mBusy ? PATTERN[LEN-1-bitNo] : 1'b1;
      et = mBusy && ((mTime % DIV) == DIV - 1);
      es = mBusy ? segRef(bitNo) : 7'b1111111;
      return {ex, mBusy, mDone, et, es};
   endfunction

   // Reference model: advances on each clock edge and queues the expected outputs.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBusy = 1'b0;
         mDone = 1'b0;
         mTime = 0;
         expQ.delete();
      end else begin
         mDone = 1'b0;
         if (!mBusy) begin
            if (start) begin
               mBusy = 1'b1;
               mTime = 0;
            end
         end else begin
            mTime++;
            if (mTime == LEN * DIV) begin
               mTime = 0;
               if (!repeat_en) begin
                  mBusy = 1'b0;
                  mDone = 1'b1;
               end
            end
         end
         expQ.push_back(modelOut());
      end
   end

   // Compare against the scoreboard away from the active edge.
   always @(negedge clk) begin
      if (!rst && expQ.size() > 0) begin
         checkOutput($sformatf("cycle@%0t", $time),
                     32'({x, busy, done, tick, a, b, c, d, e, f, g}), 32'(expQ.pop_front()));
         if (busy) busyCount++;
         if (done) doneCount++;
         if (tick) tickCount++;
      end
   end

   task automatic applyStimulus(input logic st, input logic rep, input int cycles);
      start     = st;
      repeat_en = rep;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clearCounts();
      busyCount = 0;
      doneCount = 0;
      tickCount = 0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      repeat_en = 1'b0;
      clearCounts();
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_state", 32'({x, busy, done, tick, a, b, c, d, e, f, g}), 32'({4'b1000, 7'b1111111}));
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 3);

      $display("[TB] single shot with display");
      clearCounts();
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 40);
      checkOutput("single_busy_len", busyCount, LEN * DIV);
      checkOutput("single_done_cnt", doneCount, 1);
      checkOutput("single_tick_cnt", tickCount, LEN);

      $display("[TB] repeat then drop repeat_en in second pass");
      clearCounts();
      applyStimulus(1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 39);
      checkOutput("repeat_no_done", doneCount, 0);
      applyStimulus(1'b0, 1'b0, 40);
      checkOutput("repeat_busy_len", busyCount, 2 * LEN * DIV);
      checkOutput("repeat_done_cnt", doneCount, 1);
      checkOutput("repeat_tick_cnt", tickCount, 2 * LEN);

      $display("[TB] start while busy is ignored");
      clearCounts();
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 3 * DIV);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 30);
      checkOutput("ignore_busy_len", busyCount, LEN * DIV);
      checkOutput("ignore_done_cnt", doneCount, 1);

      $display("[TB] start held high across done");
      clearCounts();
      applyStimulus(1'b1, 1'b0, LEN * DIV + 2);
      applyStimulus(1'b0, 1'b0, 40);
      checkOutput("held_busy_len", busyCount, 2 * LEN * DIV);
      checkOutput("held_done_cnt", doneCount, 2);
      checkOutput("held_tick_cnt", tickCount, 2 * LEN);

      $display("[TB] reset during bit 5");
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 5 * DIV + 1);
      checkOutput("pre_reset_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      checkOutput("rst_x", 32'(x), 1);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_tick", 32'(tick), 0);
      checkOutput("rst_segs", 32'({a, b, c, d, e, f, g}), 32'(7'b1111111));
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      clearCounts();
      applyStimulus(1'b0, 1'b0, 40);
      checkOutput("post_reset_busy", busyCount, 0);
      checkOutput("post_reset_done", doneCount, 0);
      checkOutput("post_reset_x", 32'(x), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
